rv32v_wb_sequencer: RTL and testbench
=====================================

Name: rv32v_wb_sequencer

Overview:
Writer-side driver of the vector register-file writeback port (w_data, vd, wen, vd_offset, eew, vl, single_bit_write). Sits between the vector execute/memory stages and the register file. Buffers per-cycle lane results in a small FIFO, applies tail and mask gating, and presents exactly one registered write per cycle. Tracks per-instruction completion and raises a done pulse for the scoreboard.

Parameters:
NUM_LANES, 2, lanes per write beat; matches the register file.
DEPTH, 2, result FIFO entries; power of two, at least 2.
VL_WIDTH, 7, width of the vector-length field; vl is VL_WIDTH+1 bits.

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
in_valid  in  1  result beat valid
in_ready  out  1  FIFO can accept a beat
in_data  in  32*NUM_LANES  lane results (word_t per lane)
in_vd  in  5  destination vector register
in_offset  in  VL_WIDTH  element index of lane 0
in_eew  in  2  sew_t element width
in_vl  in  VL_WIDTH+1  active vector length
in_lane_en  in  NUM_LANES  lanes producing results
in_vm  in  1  1 = unmasked instruction
in_mask  in  NUM_LANES  v0 mask bits for these elements
in_single_bit  in  1  mask-producing instruction (compare/mask-logical)
in_last  in  1  final beat of the instruction
wb_stall  in  1  hold FIFO head; no write this cycle
flush  in  1  discard all buffered beats
w_data  out  32*NUM_LANES  to rf writeback
vd  out  5  to rf writeback
wen  out  NUM_LANES  per-lane write enable
vd_offset  out  VL_WIDTH  to rf writeback
eew  out  2  to rf writeback
vl  out  VL_WIDTH+1  to rf writeback
single_bit_write  out  1  to rf writeback
done  out  1  one-cycle instruction-complete pulse
done_vd  out  5  register completed with done
elem_count  out  VL_WIDTH+1  elements written for the current instruction

Behaviour:
- Reset (nRST low, asynchronous): FIFO empty; wen=0; done=0; elem_count=0; all other outputs 0.
- Push: occurs when in_valid && in_ready. in_ready = !full and is combinational from the FIFO count only, never from in_valid.
- Pop: occurs when the FIFO is non-empty && !wb_stall && !flush.
- Output registers load from the head on pop. When no pop occurs, wen and done load 0. Data and field outputs hold their previous values.
- Latency: a beat pushed at edge N drives wen at earliest after edge N+1. Sustained throughput is one beat per cycle.
- Gating, per lane i: wen[i] = lane_en[i] && (vm || mask[i]) && (offset+i < vl). The comparison uses VL_WIDTH+1-bit arithmetic, so no wrap occurs.
- single_bit_write passes through. Offset packing for mask writes is done by the rf, not here.
- elem_count adds popcount(wen) on each pop. On a pop of an in_last beat: done=1 and done_vd=vd in the same cycle as that write; elem_count clears next cycle.
- vl=0, or all lanes gated off: the beat still pops with wen=0. An in_last beat still raises done.
- Full FIFO with simultaneous pop: in_ready stays 0 that cycle. This is a deliberate timing cut.
- Empty FIFO with simultaneous push: no bypass; the beat is written on the following cycle.
- wb_stall: head and outputs hold, wen=0, pushes continue until full.
- flush: wins over push and pop. The FIFO empties, wen=0 and done=0 next cycle, elem_count=0. An in_valid beat in the flush cycle is dropped.
- Reset during a stream: all state is lost. No partial write is emitted after nRST rises.

Optional Feature:
Macro: RV32V_WB_FORWARD_EN.
- When defined, adds outputs fwd_valid (1), fwd_vd (5), fwd_offset (VL_WIDTH), fwd_data (32*NUM_LANES) and fwd_wen (NUM_LANES). These mirror the registered write outputs for decode-stage bypass. fwd_valid = |wen.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- rv32v_types_pkg: sew_t, offset_t, NUM_LANES, VL_WIDTH, and a new packed struct wb_beat_t {data, vd, offset, eew, vl, lane_en, vm, mask, single_bit, last}.
- Sub-module rv32v_wb_fifo: a generic DEPTH-entry FIFO of wb_beat_t with push, pop, flush, full, empty and head outputs.
- The top level holds gating, output registers and the completion counter.

Test Plan:
1. Reset: assert nRST=0 mid-stream with 2 beats buffered → wen=0, in_ready=1, elem_count=0 immediately; no write appears after release.
2. Streaming: vl=8, eew=32b, vm=1, 4 back-to-back beats at offsets 0,2,4,6 with the last beat flagged → wen=2'b11 on 4 consecutive cycles starting 2 cycles after the first push; done=1 with done_vd=vd alongside the offset-6 write; elem_count reaches 8.
3. Tail: vl=5, beat at offset 4 with lane_en=11 → wen=2'b01. Beat at offset 6 → wen=2'b00 and done still fires if the beat is last.
4. Mask: vm=0, mask=2'b10, lane_en=11 → wen=2'b10 and elem_count increments by 1.
5. Backpressure: hold wb_stall=1 and push 3 beats → in_ready drops after 2. Release stall → beats write in order on 3 consecutive cycles with no loss or duplication.
6. Flush: 2 beats buffered plus a push in the flush cycle → next cycle wen=0 and done=0, FIFO empty, elem_count=0; a subsequent beat writes normally.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// -----------------------------------------------------------------------------
// rv32v_types_pkg
// Shared vector-unit types for the writeback path: element width, offset and
// vector-length field types, and the beat record that travels through the
// writeback FIFO. Also provides a lane popcount helper used for element
// accounting.
// -----------------------------------------------------------------------------
package rv32v_types_pkg;

  localparam int NUM_LANES = 2;
  localparam int VL_WIDTH  = 7;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SEW_8    = 2'd0,
    SEW_16   = 2'd1,
    SEW_32   = 2'd2,
    SEW_RSVD = 2'd3
  } sew_t;

  typedef logic [VL_WIDTH-1:0] offset_t;
  typedef logic [VL_WIDTH:0]   vl_t;

  // One per-cycle result beat: lane data plus everything needed to gate and
  // route the write once it reaches the head of the FIFO.
  typedef struct packed {
    word_t [NUM_LANES-1:0] data;
    logic [4:0]            vd;
    offset_t               offset;
    sew_t                  eew;
    vl_t                   vl;
    logic [NUM_LANES-1:0]  lane_en;
    logic                  vm;
    logic [NUM_LANES-1:0]  mask;
    logic                  single_bit;
    logic                  last;
  } wb_beat_t;

  function automatic vl_t lane_popcount(input logic [NUM_LANES-1:0] bits);
    vl_t n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n = n + vl_t'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rv32v_wb_fifo.sv
// -----------------------------------------------------------------------------
// rv32v_wb_fifo
// DEPTH-entry FIFO of wb_beat_t. Flush has priority over push and pop.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   push, push_data  enqueue request and beat (ignored when full or flushing)
//   pop              dequeue request (ignored when empty or flushing)
//   flush            discard every stored beat
//   full, empty      occupancy status, derived from the count register only
//   head             oldest stored beat (valid when !empty)
// -----------------------------------------------------------------------------
module rv32v_wb_fifo
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     push,
  input  wb_beat_t push_data,
  input  logic     pop,
  input  logic     flush,
  output logic     full,
  output logic     empty,
  output wb_beat_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_beat_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rv32v_wb_sequencer.sv
// -----------------------------------------------------------------------------
// rv32v_wb_sequencer
// Writer-side driver of the vector register-file writeback port. Buffers
// result beats in a FIFO, gates each lane by lane enable, v0 mask and tail
// (offset+i < vl), and issues one registered write per cycle. Counts written
// elements per instruction and pulses done on the final beat's write.
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   in_*               result beat from execute/memory; in_ready = FIFO not full
//   wb_stall           hold the FIFO head, no write this cycle
//   flush              drop all buffered beats (wins over push and pop)
//   w_data .. single_bit_write  registered writeback port to the rf
//   done, done_vd      one-cycle completion pulse and its destination register
//   elem_count         elements written so far for the current instruction
// Optional feature (macro RV32V_WB_FORWARD_EN): fwd_valid/fwd_vd/fwd_offset/
// fwd_data/fwd_wen mirror the registered write for decode-stage bypass.
// -----------------------------------------------------------------------------
module rv32v_wb_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 2,
  parameter int VL_WIDTH  = 7
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NUM_LANES-1:0] in_data,
  input  logic [4:0]             in_vd,
  input  logic [VL_WIDTH-1:0]    in_offset,
  input  logic [1:0]             in_eew,
  input  logic [VL_WIDTH:0]      in_vl,
  input  logic [NUM_LANES-1:0]   in_lane_en,
  input  logic                   in_vm,
  input  logic [NUM_LANES-1:0]   in_mask,
  input  logic                   in_single_bit,
  input  logic                   in_last,
  input  logic                   wb_stall,
  input  logic                   flush,
  output logic [32*NUM_LANES-1:0] w_data,
  output logic [4:0]             vd,
  output logic [NUM_LANES-1:0]   wen,
  output logic [VL_WIDTH-1:0]    vd_offset,
  output logic [1:0]             eew,
  output logic [VL_WIDTH:0]      vl,
  output logic                   single_bit_write,
  output logic                   done,
  output logic [4:0]             done_vd,
  output logic [VL_WIDTH:0]      elem_count
`ifdef RV32V_WB_FORWARD_EN
  ,
  output logic                   fwd_valid,
  output logic [4:0]             fwd_vd,
  output logic [VL_WIDTH-1:0]    fwd_offset,
  output logic [32*NUM_LANES-1:0] fwd_data,
  output logic [NUM_LANES-1:0]   fwd_wen
`endif
);

  import rv32v_types_pkg::*;

  wb_beat_t             push_beat;
  wb_beat_t             head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [NUM_LANES-1:0] gated_wen;
  vl_t                  lane_pos;
  vl_t                  elem_base;

  // in_ready depends only on occupancy; a full FIFO stays closed even in a
  // cycle where it pops, which keeps in_ready off the stall/flush path.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !fifo_empty && !wb_stall && !flush;

  always_comb begin
    push_beat            = '0;
    push_beat.data       = in_data;
    push_beat.vd         = in_vd;
    push_beat.offset     = in_offset;
    push_beat.eew        = sew_t'(in_eew);
    push_beat.vl         = in_vl;
    push_beat.lane_en    = in_lane_en;
    push_beat.vm         = in_vm;
    push_beat.mask       = in_mask;
    push_beat.single_bit = in_single_bit;
    push_beat.last       = in_last;
  end

  rv32v_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .push_data(push_beat),
    .pop      (pop),
    .flush    (flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  // Element index is widened by one bit before adding the lane number so a
  // beat near the top of the offset range cannot wrap below vl.
  always_comb begin
    gated_wen = '0;
    lane_pos  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_pos     = {1'b0, head.offset} + vl_t'(i);
      gated_wen[i] = head.lane_en[i] && (head.vm || head.mask[i]) && (lane_pos < head.vl);
    end
  end

  // The count from a finished instruction is shown alongside its done pulse
  // and restarts from zero on the following cycle.
  assign elem_base = done ? '0 : elem_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      w_data           <= '0;
      vd               <= '0;
      wen              <= '0;
      vd_offset        <= '0;
      eew              <= '0;
      vl               <= '0;
      single_bit_write <= 1'b0;
      done             <= 1'b0;
      done_vd          <= '0;
      elem_count       <= '0;
    end else if (flush) begin
      wen        <= '0;
      done       <= 1'b0;
      elem_count <= '0;
    end else if (pop) begin
      w_data           <= head.data;
      vd               <= head.vd;
      wen              <= gated_wen;
      vd_offset        <= head.offset;
      eew              <= head.eew;
      vl               <= head.vl;
      single_bit_write <= head.single_bit;
      done             <= head.last;
      if (head.last) done_vd <= head.vd;
      elem_count       <= elem_base + lane_popcount(gated_wen);
    end else begin
      wen        <= '0;
      done       <= 1'b0;
      elem_count <= elem_base;
    end
  end

`ifdef RV32V_WB_FORWARD_EN
  assign fwd_valid  = |wen;
  assign fwd_vd     = vd;
  assign fwd_offset = vd_offset;
  assign fwd_data   = w_data;
  assign fwd_wen    = wen;
`endif

endmodule

// File: tb/tb_rv32v_wb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rv32v_wb_sequencer
// Directed bench for rv32v_wb_sequencer. A queue-based model of the
// writeback behaviour is compared against the DUT every cycle, and each
// scenario also pins a few hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_rv32v_wb_sequencer;

  localparam int NUM_LANES = 2;
  localparam int DEPTH     = 2;
  localparam int VL_WIDTH  = 7;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  in_vd;
  logic [6:0]  in_offset;
  logic [1:0]  in_eew;
  logic [7:0]  in_vl;
  logic [1:0]  in_lane_en;
  logic        in_vm;
  logic [1:0]  in_mask;
  logic        in_single_bit;
  logic        in_last;
  logic        wb_stall;
  logic        flush;
  logic [63:0] w_data;
  logic [4:0]  vd;
  logic [1:0]  wen;
  logic [6:0]  vd_offset;
  logic [1:0]  eew;
  logic [7:0]  vl;
  logic        single_bit_write;
  logic        done;
  logic [4:0]  done_vd;
  logic [7:0]  elem_count;
`ifdef RV32V_WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_vd;
  logic [6:0]  fwd_offset;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_wen;
`endif

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 CLK = ~CLK;

  rv32v_wb_sequencer #(
    .NUM_LANES(NUM_LANES),
    .DEPTH    (DEPTH),
    .VL_WIDTH (VL_WIDTH)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_vd           (in_vd),
    .in_offset       (in_offset),
    .in_eew          (in_eew),
    .in_vl           (in_vl),
    .in_lane_en      (in_lane_en),
    .in_vm           (in_vm),
    .in_mask         (in_mask),
    .in_single_bit   (in_single_bit),
    .in_last         (in_last),
    .wb_stall        (wb_stall),
    .flush           (flush),
    .w_data          (w_data),
    .vd              (vd),
    .wen             (wen),
    .vd_offset       (vd_offset),
    .eew             (eew),
    .vl              (vl),
    .single_bit_write(single_bit_write),
    .done            (done),
    .done_vd         (done_vd),
    .elem_count      (elem_count)
`ifdef RV32V_WB_FORWARD_EN
    ,
    .fwd_valid       (fwd_valid),
    .fwd_vd          (fwd_vd),
    .fwd_offset      (fwd_offset),
    .fwd_data        (fwd_data),
    .fwd_wen         (fwd_wen)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending beats; each cycle the oldest beat is
  // written unless stalled or flushed, with each lane enabled only if it is
  // active, unmasked and its element index is below vl.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] data;
    logic [4:0]  vd;
    int          offset;
    logic [1:0]  eew;
    int          vl;
    logic [1:0]  lane_en;
    bit          vm;
    logic [1:0]  mask;
    bit          single_bit;
    bit          last;
  } beat_t;

  beat_t       model_q[$];
  logic [1:0]  exp_wen;
  bit          exp_done;
  int          exp_count;
  logic [63:0] exp_data;
  logic [4:0]  exp_vd;
  int          exp_offset;
  logic [1:0]  exp_eew;
  int          exp_vl;
  bit          exp_single;
  logic [4:0]  exp_done_vd;

  beat_t mb;
  beat_t nb;
  int    mbase;
  bit    mready;

  task automatic modelReset();
    model_q.delete();
    exp_wen     = '0;
    exp_done    = 1'b0;
    exp_count   = 0;
    exp_data    = '0;
    exp_vd      = '0;
    exp_offset  = 0;
    exp_eew     = '0;
    exp_vl      = 0;
    exp_single  = 1'b0;
    exp_done_vd = '0;
  endtask

  always @(negedge nRST) modelReset();

  always @(posedge CLK) begin
    if (!nRST) begin
      modelReset();
    end else begin
      mready = model_q.size() < DEPTH;
      mbase  = exp_done ? 0 : exp_count;
      if (flush) begin
        model_q.delete();
        exp_wen   = '0;
        exp_done  = 1'b0;
        exp_count = 0;
      end else begin
        if (model_q.size() > 0 && !wb_stall) begin
          mb = model_q.pop_front();
          exp_wen = '0;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (mb.lane_en[i] && (mb.vm || mb.mask[i]) && (mb.offset + i < mb.vl))
              exp_wen[i] = 1'b1;
          end
          exp_count  = mbase + $countones(exp_wen);
          exp_done   = mb.last;
          exp_data   = mb.data;
          exp_vd     = mb.vd;
          exp_offset = mb.offset;
          exp_eew    = mb.eew;
          exp_vl     = mb.vl;
          exp_single = mb.single_bit;
          if (mb.last) exp_done_vd = mb.vd;
        end else begin
          exp_wen   = '0;
          exp_done  = 1'b0;
          exp_count = mbase;
        end
        if (in_valid && mready) begin
          nb.data       = in_data;
          nb.vd         = in_vd;
          nb.offset     = int'(in_offset);
          nb.eew        = in_eew;
          nb.vl         = int'(in_vl);
          nb.lane_en    = in_lane_en;
          nb.vm         = in_vm;
          nb.mask       = in_mask;
          nb.single_bit = in_single_bit;
          nb.last       = in_last;
          model_q.push_back(nb);
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (checking) begin
      checkOutput("cmp_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
      checkOutput("cmp_wen", 64'(wen), 64'(exp_wen));
      checkOutput("cmp_done", 64'(done), 64'(exp_done));
      checkOutput("cmp_elem_count", 64'(elem_count), 64'(exp_count));
      checkOutput("cmp_w_data", w_data, exp_data);
      checkOutput("cmp_vd", 64'(vd), 64'(exp_vd));
      checkOutput("cmp_vd_offset", 64'(vd_offset), 64'(exp_offset));
      checkOutput("cmp_eew", 64'(eew), 64'(exp_eew));
      checkOutput("cmp_vl", 64'(vl), 64'(exp_vl));
      checkOutput("cmp_single_bit", 64'(single_bit_write), 64'(exp_single));
      checkOutput("cmp_done_vd", 64'(done_vd), 64'(exp_done_vd));
`ifdef RV32V_WB_FORWARD_EN
      checkOutput("cmp_fwd_valid", 64'(fwd_valid), 64'(|exp_wen));
      checkOutput("cmp_fwd_wen", 64'(fwd_wen), 64'(exp_wen));
      checkOutput("cmp_fwd_data", fwd_data, exp_data);
      checkOutput("cmp_fwd_vd", 64'(fwd_vd), 64'(exp_vd));
      checkOutput("cmp_fwd_offset", 64'(fwd_offset), 64'(exp_offset));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2ns after a rising edge; literal checks
  // are made at the same point, so registered outputs reflect the last edge.
  // ---------------------------------------------------------------------------
  task automatic stepCycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input bit valid, input logic [63:0] data, input logic [4:0] vdv,
                               input int offset, input logic [1:0] eewv, input int vlv,
                               input logic [1:0] lane_en, input bit vm, input logic [1:0] mask,
                               input bit single, input bit last);
    in_valid      = valid;
    in_data       = data;
    in_vd         = vdv;
    in_offset     = 7'(offset);
    in_eew        = eewv;
    in_vl         = 8'(vlv);
    in_lane_en    = lane_en;
    in_vm         = vm;
    in_mask       = mask;
    in_single_bit = single;
    in_last       = last;
  endtask

  // Presents a beat until the DUT accepts it; in_ready only moves on a clock
  // edge, so its value between edges decides acceptance at the next edge.
  task automatic sendBeat(input logic [63:0] data, input logic [4:0] vdv, input int offset,
                          input int vlv, input logic [1:0] lane_en, input bit vm,
                          input logic [1:0] mask, input bit last);
    bit accepted;
    accepted = 1'b0;
    applyStimulus(1'b1, data, vdv, offset, 2'd2, vlv, lane_en, vm, mask, 1'b0, last);
    for (int n = 0; n < 20 && !accepted; n++) begin
      accepted = in_ready;
      stepCycle();
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: in_ready stayed 0, wanted 1 within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      if (done === 1'b1) seen = 1'b1;
      else stepCycle();
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  initial begin
    modelReset();
    nRST     = 1'b0;
    wb_stall = 1'b0;
    flush    = 1'b0;
    applyStimulus(1'b0, '0, '0, 0, 2'd0, 0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    stepCycle();
    checking = 1'b1;
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rst_wen", 64'(wen), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_elem_count", 64'(elem_count), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_w_data", w_data, 64'd0);
    nRST = 1'b1;
    stepCycle();

    $display("[TB] streaming vl=8");
    sendBeat(64'hA000_0001_A000_0000, 5'd3, 0, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'hA000_0003_A000_0002, 5'd3, 2, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'hA000_0005_A000_0004, 5'd3, 4, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'hA000_0007_A000_0006, 5'd3, 6, 8, 2'b11, 1'b1, 2'b00, 1'b1);
    waitDone("stream_done_seen");
    checkOutput("stream_wen", 64'(wen), 64'h3);
    checkOutput("stream_offset", 64'(vd_offset), 64'd6);
    checkOutput("stream_done_vd", 64'(done_vd), 64'd3);
    checkOutput("stream_elem_count", 64'(elem_count), 64'd8);
    stepCycle();
    checkOutput("stream_count_clear", 64'(elem_count), 64'd0);

    $display("[TB] tail vl=5 and vl=0");
    sendBeat(64'hB000_0005_B000_0004, 5'd4, 4, 5, 2'b11, 1'b1, 2'b00, 1'b0);
    stepCycle();
    checkOutput("tail_wen_partial", 64'(wen), 64'h1);
    checkOutput("tail_count_partial", 64'(elem_count), 64'd1);
    sendBeat(64'hB000_0007_B000_0006, 5'd4, 6, 5, 2'b11, 1'b1, 2'b00, 1'b1);
    stepCycle();
    checkOutput("tail_wen_off", 64'(wen), 64'h0);
    checkOutput("tail_done", 64'(done), 64'd1);
    checkOutput("tail_count_final", 64'(elem_count), 64'd1);
    sendBeat(64'hC000_0001_C000_0000, 5'd5, 0, 0, 2'b11, 1'b1, 2'b00, 1'b1);
    stepCycle();
    checkOutput("vl0_wen", 64'(wen), 64'h0);
    checkOutput("vl0_done", 64'(done), 64'd1);
    checkOutput("vl0_done_vd", 64'(done_vd), 64'd5);

    $display("[TB] mask");
    sendBeat(64'hD000_0001_D000_0000, 5'd7, 0, 8, 2'b11, 1'b0, 2'b10, 1'b1);
    stepCycle();
    checkOutput("mask_wen", 64'(wen), 64'h2);
    checkOutput("mask_count", 64'(elem_count), 64'd1);

    $display("[TB] backpressure");
    stepCycle();
    wb_stall = 1'b1;
    sendBeat(64'hE000_0001_E000_0000, 5'd9, 0, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'hE000_0003_E000_0002, 5'd9, 2, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
    checkOutput("bp_wen_stalled", 64'(wen), 64'h0);
    wb_stall = 1'b0;
    sendBeat(64'hE000_0005_E000_0004, 5'd9, 4, 8, 2'b11, 1'b1, 2'b00, 1'b1);
    waitDone("bp_done_seen");
    checkOutput("bp_last_offset", 64'(vd_offset), 64'd4);
    checkOutput("bp_elem_count", 64'(elem_count), 64'd6);
    checkOutput("bp_done_vd", 64'(done_vd), 64'd9);

    $display("[TB] flush");
    stepCycle();
    sendBeat(64'hF000_0001_F000_0000, 5'd11, 0, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    stepCycle();
    checkOutput("flush_pre_count", 64'(elem_count), 64'd2);
    wb_stall = 1'b1;
    sendBeat(64'hF000_0003_F000_0002, 5'd11, 2, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'hF000_0005_F000_0004, 5'd11, 4, 8, 2'b11, 1'b1, 2'b00, 1'b1);
    applyStimulus(1'b1, 64'hF000_0007_F000_0006, 5'd11, 6, 2'd2, 8, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1);
    flush = 1'b1;
    stepCycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_wen", 64'(wen), 64'h0);
    checkOutput("flush_done", 64'(done), 64'd0);
    checkOutput("flush_count", 64'(elem_count), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    wb_stall = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("flush_no_leftover", 64'(wen), 64'h0);
    sendBeat(64'h1234_5678_9ABC_DEF0, 5'd12, 2, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    stepCycle();
    checkOutput("post_flush_wen", 64'(wen), 64'h3);
    checkOutput("post_flush_offset", 64'(vd_offset), 64'd2);
    checkOutput("post_flush_count", 64'(elem_count), 64'd2);

    $display("[TB] reset mid-stream");
    wb_stall = 1'b1;
    sendBeat(64'h5555_0001_5555_0000, 5'd13, 0, 8, 2'b11, 1'b1, 2'b00, 1'b0);
    sendBeat(64'h5555_0003_5555_0002, 5'd13, 2, 8, 2'b11, 1'b1, 2'b00, 1'b1);
    nRST = 1'b0;
    #1;
    checkOutput("mid_rst_wen", 64'(wen), 64'h0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_count", 64'(elem_count), 64'd0);
    stepCycle();
    stepCycle();
    nRST     = 1'b1;
    wb_stall = 1'b0;
    for (int n = 0; n < 4; n++) begin
      stepCycle();
      checkOutput("post_rst_no_write", 64'(wen), 64'h0);
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, wanted completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
